// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) vs FIFO-buffered
// multi-cycle unit (B). Optional perf counters under REGARB_PERF_EN.
//
// Ports:
//   clk, reset                      clock, sync active-high reset
//   a_valid/a_addr/a_data, a_stall  writeback request and stall back
//   b_valid/b_addr/b_data, b_ready  multi-cycle unit valid/ready handshake
//   rf_we/rf_waddr/rf_wdata         registered write port to register file
//   busy_query, busy_hit            pending-write lookup for the hazard unit
//   stall_cnt, b_block_cnt          perf counters (REGARB_PERF_EN only)
module regfile_wport_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [4:0]       a_addr,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_stall,
    input  logic             b_valid,
    input  logic [4:0]       b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    input  logic [4:0]       busy_query,
    output logic             busy_hit
`ifdef REGARB_PERF_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      b_block_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [4:0]       addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q, count;
    logic [SW-1:0]    starve_q, starve_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic empty, full, force_b, grant_a, pop, push;
    logic fifo_hit;
    logic [AW-1:0] idx;

    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    // Same index, opposite lap bit: writer is a full lap ahead.
    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign force_b = (starve_q == SW'(STARVE_MAX)) && !empty;
    assign grant_a = !reset && a_valid && !force_b;
    assign pop     = !reset && !empty && (force_b || !a_valid);
    assign a_stall = !reset && a_valid && force_b;
    assign b_ready = !reset && !full;
    // r0 writes complete the handshake but are dropped here.
    assign push    = b_valid && b_ready && (b_addr != 5'd0);

    always_comb begin
        fifo_hit = 1'b0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q[AW-1:0] + AW'(k);
            if ((PW'(k) < count) && (addr_q[idx] == busy_query))
                fifo_hit = 1'b1;
        end
    end

    assign busy_hit = (busy_query != 5'd0) &&
                      (fifo_hit || (rf_we_q && rf_waddr_q == busy_query));

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_a && a_addr != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = a_addr;
            rf_wdata_d = a_data;
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_q[rptr_q[AW-1:0]];
            rf_wdata_d = data_q[rptr_q[AW-1:0]];
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || empty)
            starve_d = '0;
        else if (grant_a && starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wptr_q[AW-1:0]] <= b_addr;
            data_q[wptr_q[AW-1:0]] <= b_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef REGARB_PERF_EN
    logic [15:0] stall_cnt_q, b_block_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q   <= '0;
            b_block_cnt_q <= '0;
        end else begin
            if (a_stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (b_valid && !b_ready && b_block_cnt_q != 16'hFFFF)
                b_block_cnt_q <= b_block_cnt_q + 16'd1;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign b_block_cnt = b_block_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter with a write scoreboard.
module tb_regfile_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr, busy_query;
    logic [31:0] a_data, b_data;
    logic        a_stall, b_ready, rf_we, busy_hit;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef REGARB_PERF_EN
    logic [15:0] stall_cnt, b_block_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [36:0] sb[$];
    logic [31:0] regs [32];

    regfile_wport_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_stall    (a_stall),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy_query (busy_query),
        .busy_hit   (busy_hit)
`ifdef REGARB_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .b_block_cnt(b_block_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic sbp(input logic [4:0] ad, input logic [31:0] d);
        sb.push_back({ad, d});
    endtask

    // Register file model: captures at negedge, checks each write in order.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            logic [36:0] e;
            chk("rf_waddr_nonzero", 64'(rf_waddr != 5'd0), 64'd1);
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none",
                       rf_waddr, rf_wdata);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("write_order", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
            end
            regs[rf_waddr] = rf_wdata;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        reset = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        busy_query = 5'd3;

        // Reset
        step();
        mid();
        chk("rst_b_ready", b_ready, 0);
        chk("rst_a_stall", a_stall, 0);
        step();
        reset = 1'b0;
        mid();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("post_rst_b_ready", b_ready, 1);
        chk("rst_busy_hit", busy_hit, 0);

        // A only
        step();
        a_valid = 1; a_addr = 8; a_data = 32'h1234;
        sbp(8, 32'h1234);
        mid();
        chk("a_only_stall", a_stall, 0);
        step();
        a_valid = 0;
        mid();
        chk("a_only_we", rf_we, 1);
        chk("a_only_waddr", rf_waddr, 8);
        chk("a_only_reg8", regs[8], 32'h1234);

        // B idle path
        step();
        b_valid = 1; b_addr = 16; b_data = 32'hCAFE;
        busy_query = 16;
        sbp(16, 32'hCAFE);
        mid();
        chk("b_idle_ready", b_ready, 1);
        chk("b_idle_hit_push", busy_hit, 0);
        step();
        b_valid = 0;
        mid();
        chk("b_idle_hit_fifo", busy_hit, 1);
        step();
        mid();
        chk("b_idle_hit_rf", busy_hit, 1);
        chk("b_idle_waddr", rf_waddr, 16);
        chk("b_idle_reg16", regs[16], 32'hCAFE);
        step();
        mid();
        chk("b_idle_hit_done", busy_hit, 0);
        chk("b_idle_we_done", rf_we, 0);

        // Starvation
        step();
        a_valid = 1; a_addr = 9; a_data = 32'h900;
        b_valid = 1; b_addr = 5; b_data = 32'h55;
        sbp(9, 32'h900);
        mid();
        chk("starve_c0", a_stall, 0);
        step();
        b_valid = 0;
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) step();
            a_addr = 5'(9 + i); a_data = 32'h900 + 32'(i);
            sbp(a_addr, a_data);
            mid();
            chk("starve_a_granted", a_stall, 0);
        end
        step();
        a_addr = 13; a_data = 32'h913;
        sbp(5, 32'h55);
        mid();
        chk("starve_forced", a_stall, 1);
        step();
        sbp(13, 32'h913);
        mid();
        chk("starve_release", a_stall, 0);
        step();
        a_valid = 0;
        mid();
        chk("starve_reg5", regs[5], 32'h55);

        // Full FIFO
        for (int i = 0; i < 4; i++) begin
            step();
            a_valid = 1; a_addr = 5'(20 + i); a_data = 32'h2000 + 32'(i);
            b_valid = 1; b_addr = 5'(1 + i);  b_data = 32'hB0 + 32'(i);
            sbp(a_addr, a_data);
            mid();
            chk("full_push_ready", b_ready, 1);
            chk("full_push_stall", a_stall, 0);
        end
        step();
        a_addr = 24; a_data = 32'h2004;
        b_addr = 6; b_data = 32'hB6;
        sbp(1, 32'hB0);
        mid();
        chk("full_ready_low", b_ready, 0);
        chk("full_force", a_stall, 1);
        step();
        busy_query = 4;
        sbp(24, 32'h2004);
        mid();
        chk("full_ready_back", b_ready, 1);
        chk("full_stall_clear", a_stall, 0);
        chk("full_hit_q4", busy_hit, 1);
        step();
        a_valid = 0; b_valid = 0;
        busy_query = 6;
        sbp(2, 32'hB1); sbp(3, 32'hB2); sbp(4, 32'hB3); sbp(6, 32'hB6);
        repeat (6) step();
        mid();
        chk("full_drained_hit", busy_hit, 0);
        chk("full_reg6", regs[6], 32'hB6);

        // Zero register
        step();
        a_valid = 1; a_addr = 0; a_data = 32'hDEAD;
        b_valid = 1; b_addr = 0; b_data = 32'hBEEF;
        busy_query = 0;
        mid();
        chk("zero_a_stall", a_stall, 0);
        chk("zero_b_ready", b_ready, 1);
        chk("zero_busy_hit", busy_hit, 0);
        step();
        a_valid = 0; b_valid = 0;
        mid();
        chk("zero_we_1", rf_we, 0);
        step();
        mid();
        chk("zero_we_2", rf_we, 0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            step();
            a_valid = 1; a_addr = 5'(25 + i); a_data = 32'h2500 + 32'(i);
            b_valid = 1; b_addr = 5'(17 + i); b_data = 32'h700 + 32'(i);
            sbp(a_addr, a_data);
            mid();
        end
        step();
        a_valid = 0; b_valid = 0;
        reset = 1; busy_query = 17;
        mid();
        chk("midrst_b_ready", b_ready, 0);
        chk("midrst_a_stall", a_stall, 0);
        chk("midrst_hit", busy_hit, 1);
        chk("midrst_last_we", rf_we, 1);
        step();
        reset = 0;
        mid();
        chk("midrst_we_after", rf_we, 0);
        chk("midrst_ready_after", b_ready, 1);
        chk("midrst_hit_after", busy_hit, 0);
        repeat (4) step();
        mid();
        chk("midrst_reg17", regs[17], 0);
        chk("midrst_reg18", regs[18], 0);
        chk("midrst_reg19", regs[19], 0);
        chk("midrst_reg27", regs[27], 32'h2502);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port (RegWrite/WriteRegister/WriteData) between two writers.
- Writer A is the pipeline writeback stage: high priority, and it can be stalled only by this block.
- Writer B is a multi-cycle unit (mult/div) using a valid/ready handshake, buffered in a small FIFO.
- Also provides a pending-write lookup so the hazard unit can stall reads of registers still queued for writing.

Parameters:
- WIDTH, 32, data width of the write port.
- DEPTH, 4, number of B FIFO entries; must be a power of two, minimum 2.
- STARVE_MAX, 3, consecutive cycles B's FIFO head may lose to A before A is stalled.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  writeback stage requests a write this cycle.
- a_addr  input  5  writeback destination register.
- a_data  input  WIDTH  writeback data.
- a_stall  output  1  A not granted this cycle; writeback stage must hold its request.
- b_valid  input  1  multi-cycle unit offers a write.
- b_addr  input  5  multi-cycle unit destination register.
- b_data  input  WIDTH  multi-cycle unit data.
- b_ready  output  1  FIFO can accept the B write this cycle.
- rf_we  output  1  to register file RegWrite.
- rf_waddr  output  5  to register file WriteRegister.
- rf_wdata  output  WIDTH  to register file WriteData.
- busy_query  input  5  register number checked by the hazard unit.
- busy_hit  output  1  busy_query has a write pending.

Behaviour:
- Reset (sync, clk posedge with reset=1):
  - FIFO empty; read/write pointers 0; starve_cnt 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - a_stall=0 and b_ready=0 while reset is high.
- Reset mid-operation discards all queued B writes and any pending output write. A write already registered on rf_* before the reset edge still lands at the following negedge.
- Output stage is registered:
  - A write granted in cycle N drives rf_* during cycle N+1.
  - The register file captures it at the negedge of cycle N+1, so latency is 1.5 clk from grant to register update.
  - With no grant, rf_we=0 next cycle; rf_waddr and rf_wdata hold their last values.
- Grant priority, evaluated each cycle:
  1. force = (starve_cnt == STARVE_MAX) and FIFO non-empty. If force, grant the FIFO head (pop) and assert a_stall if a_valid.
  2. Else if a_valid, grant A; a_stall=0.
  3. Else if FIFO non-empty, grant the FIFO head (pop).
  4. Else no grant.
- a_stall is combinational: a_valid and force. It is never asserted when a_valid=0.
- starve_cnt:
  - Reset to 0 on any pop or when the FIFO is empty.
  - Otherwise +1 per cycle where the FIFO is non-empty and A was granted.
  - Saturates at STARVE_MAX.
- B handshake:
  - b_ready = !full (combinational, and 0 during reset).
  - Push occurs when b_valid and b_ready.
  - No pop-through when full: b_ready stays 0 for the whole full cycle, even if a pop occurs in that cycle.
  - Push and pop in the same cycle (not full) are both performed; occupancy is unchanged.
- Register 0 handling:
  - A B write with b_addr=0 completes the handshake but is not stored.
  - An A write with a_addr=0 is granted (a_stall=0) but produces rf_we=0.
  - rf_we is never 1 with rf_waddr=0.
- Ordering:
  - B writes leave the FIFO in push order.
  - No ordering is enforced between A and B to the same register; the hazard unit uses busy_hit to prevent WAW/RAW conflicts.
- busy_hit = (busy_query != 0) and (busy_query matches any valid FIFO entry, or rf_we=1 with rf_waddr == busy_query).
  - Combinational.
  - Does not include the B write being pushed in the current cycle.
- Occupancy uses log2(DEPTH)+1-bit pointers; full and empty are derived from pointer MSB/LSB comparison, with wrap-around at DEPTH.

Optional Feature:
- Macro: REGARB_PERF_EN.
- Defined:
  - Adds output port stall_cnt (16 bits) counting cycles with a_stall=1, saturating at 16'hFFFF.
  - Adds output port b_block_cnt (16 bits) counting cycles with b_valid=1 and b_ready=0, saturating at 16'hFFFF.
  - Both counters clear on reset.
- Undefined: neither port nor either counter exists; behaviour is otherwise identical.

Test Plan:
- A only: a_valid=1, a_addr=8, a_data=32'h1234 for 1 cycle -> next cycle rf_we=1, rf_waddr=8, rf_wdata=32'h1234; register 8 = 32'h1234 after negedge; a_stall=0.
- B idle path: b_valid=1, b_addr=16, b_data=32'hCAFE with a_valid=0 -> pushed, popped the next cycle; rf_we=1, rf_waddr=16 one cycle later; busy_query=16 gives busy_hit=1 until rf_we drops.
- Starvation: FIFO holds one entry and a_valid=1 continuously with STARVE_MAX=3 -> A granted 3 cycles; 4th cycle a_stall=1 and the FIFO head is written; a_stall=0 the following cycle.
- Full FIFO: push 4 B writes while a_valid=1 continuously -> b_ready=0 after the 4th push; a 5th b_valid is held; b_ready returns to 1 the cycle after the first pop.
- Zero register: a_addr=0 and b_addr=0 writes -> both handshakes complete; rf_we never 1; busy_query=0 gives busy_hit=0.
- Reset mid-operation: 3 FIFO entries queued, reset=1 for 1 cycle -> FIFO empty, rf_we=0, b_ready=0 during reset and 1 after; no queued write reaches the register file.
